// File: rtl/norm_shift_if.sv
// Start/busy/done handshake between the MCU control logic and the sequential normalizer.
// The master is the controller and the slave is norm_shift_seq.
interface norm_shift_if;
  logic        start;
  logic        arith;
  logic [15:0] in_16;
  logic [15:0] out_16;
  logic [4:0]  count;
  logic        zero;
  logic        busy;
  logic        done;

  modport master (
    output start, arith, in_16,
    input  out_16, count, zero, busy, done
  );

  modport slave (
    input  start, arith, in_16,
    output out_16, count, zero, busy, done
  );
endinterface

// File: rtl/norm_shift_seq.sv
// Sequential 16-bit normalizer: shifts the operand left one bit per clock until it is normalized.
// Define NORM_EARLY_ZERO_EN to send zero/all-sign operands straight from IDLE to DONE.
module norm_shift_seq (
  input  logic          clk,
  input  logic          rst,
  norm_shift_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] data;
  logic [4:0]  cnt;
  logic        mode;
  logic        zero_r;
  logic        busy_r;
  logic        done_r;

  logic        in_zero;
  logic        stop;

  // NOTE: combinational blocks assign every output first, so no path can infer a latch.
  always_comb begin
    in_zero = (bus.in_16 == 16'h0000) || (bus.arith && (bus.in_16 == 16'hFFFF));
    stop    = 1'b0;
    if (mode) stop = (data[15] ^ data[14]) || (cnt == 5'd15);
    else      stop = data[15] || (cnt == 5'd16);
  end

  // NOTE: all state here updates with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      data   <= '0;
      cnt    <= '0;
      mode   <= 1'b0;
      zero_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            mode   <= bus.arith;
            zero_r <= in_zero;
`ifdef NORM_EARLY_ZERO_EN
            if (in_zero) begin
              // A signed 0xFFFF ends as a lone sign bit after 15 logical shifts.
              data   <= (bus.arith && bus.in_16[15]) ? 16'h8000 : 16'h0000;
              cnt    <= bus.arith ? 5'd15 : 5'd16;
              done_r <= 1'b1;
              state  <= DONE;
            end else begin
              data   <= bus.in_16;
              cnt    <= '0;
              busy_r <= 1'b1;
              state  <= SHIFT;
            end
`else
            data   <= bus.in_16;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= SHIFT;
`endif
          end
        end

        SHIFT: begin
          if (stop) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            data <= {data[14:0], 1'b0};
            cnt  <= cnt + 5'd1;
          end
        end

        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_16 = data;
  assign bus.count  = cnt;
  assign bus.zero   = zero_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;

endmodule
